// File: rtl/irq_sequencer_if.sv
// Bundle between the pipeline front end and the interrupt sequencer: raw sources,
// enable-register write port, issue blockers, handler returns and status back.
interface irq_sequencer_if #(
    parameter int NUM_SRC = 4
);
    localparam int CW = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0] irq_src;
    logic               irq_en_we;
    logic [NUM_SRC-1:0] irq_en_wdata;
    logic               stall_mem;
    logic               flush;
    logic               hazard;
    logic               halt;
    logic               rti;
    logic               rsi;
    logic               interrupt;
    logic               irq_active;
    logic [CW-1:0]      irq_cause;
    logic [NUM_SRC-1:0] irq_pending;
    logic [NUM_SRC-1:0] irq_en;

    modport master (
        output irq_src, irq_en_we, irq_en_wdata, stall_mem, flush, hazard, halt, rti, rsi,
        input  interrupt, irq_active, irq_cause, irq_pending, irq_en
    );

    modport slave (
        input  irq_src, irq_en_we, irq_en_wdata, stall_mem, flush, hazard, halt, rti, rsi,
        output interrupt, irq_active, irq_cause, irq_pending, irq_en
    );
endinterface

// File: rtl/irq_sequencer.sv
// Edge-triggered interrupt collector with fixed lowest-index priority; sequences
// issue, handler residency and a post-return settle window for the fetch stage.
module irq_sequencer #(
    parameter int NUM_SRC     = 4,
    parameter int HOLDOFF_CYC = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    irq_sequencer_if.slave bus
);
    localparam int CW    = $clog2(NUM_SRC);
    localparam int CNT_W = $clog2(HOLDOFF_CYC + 1);

    typedef enum logic [2:0] {IDLE, ARM, ISSUE, ACTIVE, HOLDOFF} state_e;

    state_e             state_q, state_d;
    logic [NUM_SRC-1:0] src_q, src_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] en_q, en_d;
    logic [CW-1:0]      cause_q, cause_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               interrupt_q, interrupt_d;
    logic               active_q, active_d;

    logic [NUM_SRC-1:0] rise, eligible, pick_oh, clr;
    logic [CW-1:0]      pick_idx;
    logic               safe;

    // Descending scan so the lowest eligible index is the last one written.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        rise     = bus.irq_src & ~src_q;
        eligible = pending_q & en_q;
        safe     = ~(bus.stall_mem | bus.flush | bus.hazard | bus.halt);
        pick_idx = '0;
        pick_oh  = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                pick_idx    = CW'(i);
                pick_oh     = '0;
                pick_oh[i]  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        cnt_d   = cnt_q;
        clr     = '0;
        unique case (state_q)
            IDLE:    if (|eligible) state_d = ARM;
            ARM: begin
                if (eligible == '0) begin
                    state_d = IDLE;
                end else if (safe) begin
                    state_d = ISSUE;
                    cause_d = pick_idx;
                    clr     = pick_oh;
                end
            end
            ISSUE:   state_d = ACTIVE;
            ACTIVE: begin
                if (bus.rti | bus.rsi) begin
                    state_d = HOLDOFF;
                    cnt_d   = CNT_W'(HOLDOFF_CYC - 1);
                end
            end
            HOLDOFF: begin
                cnt_d = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A new edge wins over the issue-time clear of the same bit.
        pending_d   = (pending_q & ~clr) | rise;
        en_d        = bus.irq_en_we ? bus.irq_en_wdata : en_q;
        src_d       = bus.irq_src;
        interrupt_d = (state_d == ISSUE);
        active_d    = (state_d == ISSUE) || (state_d == ACTIVE);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        // The source copy keeps tracking during reset, so a line held high through reset shows no edge.
        src_q <= src_d;
        if (!rst_n) begin
            // NOTE: reset covers every control flop; there is no storage array here that could be left unreset.
            state_q     <= IDLE;
            pending_q   <= '0;
            en_q        <= '0;
            cause_q     <= '0;
            cnt_q       <= '0;
            interrupt_q <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            en_q        <= en_d;
            cause_q     <= cause_d;
            cnt_q       <= cnt_d;
            interrupt_q <= interrupt_d;
            active_q    <= active_d;
        end
    end

    assign bus.interrupt   = interrupt_q;
    assign bus.irq_active  = active_q;
    assign bus.irq_cause   = cause_q;
    assign bus.irq_pending = pending_q;
    assign bus.irq_en      = en_q;
endmodule

// File: tb/tb_irq_sequencer.sv
// Directed bench for irq_sequencer: reset, single issue, priority, stall hold-off,
// masking, reset mid-handler and same-cycle set/clear of a pending bit.
module tb_irq_sequencer;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    irq_sequencer_if #(.NUM_SRC(4)) bus ();

    irq_sequencer #(.NUM_SRC(4), .HOLDOFF_CYC(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_en(input logic [3:0] mask);
        bus.irq_en_we    = 1'b1;
        bus.irq_en_wdata = mask;
        tick();
        bus.irq_en_we    = 1'b0;
    endtask

    task automatic pulse_src(input logic [3:0] lines);
        bus.irq_src = lines;
        tick();
        bus.irq_src = 4'b0000;
    endtask

    // Return from ACTIVE with rti, then sit out the settle window back to IDLE.
    task automatic finish_handler(input string tag);
        bus.rti = 1'b1;
        tick();
        bus.rti = 1'b0;
        check({tag, "_ret_active"}, 16'(bus.irq_active), 16'd0);
        tick();
        check({tag, "_hold_int"}, 16'(bus.interrupt), 16'd0);
        tick();
    endtask

    initial begin
        n_cmp            = 0;
        n_err            = 0;
        rst_n            = 1'b0;
        bus.irq_src      = 4'hF;
        bus.irq_en_we    = 1'b0;
        bus.irq_en_wdata = 4'h0;
        bus.stall_mem    = 1'b0;
        bus.flush        = 1'b0;
        bus.hazard       = 1'b0;
        bus.halt         = 1'b0;
        bus.rti          = 1'b0;
        bus.rsi          = 1'b0;

        // 1. Reset with all sources high
        tick();
        tick();
        check("rst_int",     16'(bus.interrupt),   16'd0);
        check("rst_active",  16'(bus.irq_active),  16'd0);
        check("rst_cause",   16'(bus.irq_cause),   16'd0);
        check("rst_pending", 16'(bus.irq_pending), 16'd0);
        check("rst_en",      16'(bus.irq_en),      16'd0);
        rst_n = 1'b1;
        tick();
        tick();
        check("post_rst_pending", 16'(bus.irq_pending), 16'd0);
        check("post_rst_int",     16'(bus.interrupt),   16'd0);
        bus.irq_src = 4'h0;
        tick();

        // 2. Single source, safe throughout
        write_en(4'b0010);
        check("s_en", 16'(bus.irq_en), 16'b0010);
        pulse_src(4'b0010);
        check("s_pend", 16'(bus.irq_pending), 16'b0010);
        check("s_int_e0", 16'(bus.interrupt), 16'd0);
        tick();
        check("s_int_e1", 16'(bus.interrupt), 16'd0);
        tick();
        check("s_int", 16'(bus.interrupt), 16'd1);
        check("s_cause", 16'(bus.irq_cause), 16'd1);
        check("s_active", 16'(bus.irq_active), 16'd1);
        check("s_pend_clr", 16'(bus.irq_pending), 16'd0);
        tick();
        check("s_int_once", 16'(bus.interrupt), 16'd0);
        check("s_active_hold", 16'(bus.irq_active), 16'd1);
        finish_handler("s");

        // 3. Priority, rsi return, second issue after the settle window
        write_en(4'b0101);
        pulse_src(4'b0101);
        tick();
        tick();
        check("p_int", 16'(bus.interrupt), 16'd1);
        check("p_cause", 16'(bus.irq_cause), 16'd0);
        check("p_pend", 16'(bus.irq_pending), 16'b0100);
        tick();
        bus.rsi = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            bus.rsi = 1'b0;
            check($sformatf("p_gap%0d", k), 16'(bus.interrupt), (k == 5) ? 16'd1 : 16'd0);
        end
        check("p_cause2", 16'(bus.irq_cause), 16'd2);
        check("p_pend2", 16'(bus.irq_pending), 16'd0);
        tick();
        finish_handler("p");

        // 4. Stall held for five ARM cycles
        pulse_src(4'b0001);
        bus.stall_mem = 1'b1;
        tick();
        for (int k = 1; k <= 5; k++) begin
            check($sformatf("st_int%0d", k), 16'(bus.interrupt), 16'd0);
            check($sformatf("st_cause%0d", k), 16'(bus.irq_cause), 16'd2);
            if (k == 5) bus.stall_mem = 1'b0;
            tick();
        end
        check("st_issue", 16'(bus.interrupt), 16'd1);
        check("st_cause", 16'(bus.irq_cause), 16'd0);
        tick();
        finish_handler("st");

        // 5. Masked source, later enabled; then mask cleared during ARM
        pulse_src(4'b1000);
        check("m_pend", 16'(bus.irq_pending), 16'b1000);
        for (int k = 1; k <= 3; k++) begin
            tick();
            check($sformatf("m_noint%0d", k), 16'(bus.interrupt), 16'd0);
        end
        write_en(4'b1000);
        check("m_w1", 16'(bus.interrupt), 16'd0);
        tick();
        check("m_w2", 16'(bus.interrupt), 16'd0);
        tick();
        check("m_w3", 16'(bus.interrupt), 16'd1);
        check("m_cause", 16'(bus.irq_cause), 16'd3);
        tick();
        finish_handler("m");
        pulse_src(4'b1000);
        bus.stall_mem = 1'b1;
        tick();
        write_en(4'b0000);
        tick();
        bus.stall_mem = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("m_clr_int%0d", k), 16'(bus.interrupt), 16'd0);
        end
        check("m_clr_pend", 16'(bus.irq_pending), 16'b1000);
        check("m_clr_active", 16'(bus.irq_active), 16'd0);

        // 6. Reset while a handler is active and another source is pending
        write_en(4'b0011);
        pulse_src(4'b0011);
        tick();
        tick();
        tick();
        check("r_active", 16'(bus.irq_active), 16'd1);
        check("r_pend", 16'(bus.irq_pending), 16'b1010);
        rst_n = 1'b0;
        tick();
        check("r_active0", 16'(bus.irq_active), 16'd0);
        check("r_pend0", 16'(bus.irq_pending), 16'd0);
        check("r_en0", 16'(bus.irq_en), 16'd0);
        check("r_cause0", 16'(bus.irq_cause), 16'd0);
        check("r_int0", 16'(bus.interrupt), 16'd0);
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("r_noint%0d", k), 16'(bus.interrupt), 16'd0);
        end

        // 7. New edge on the bit being cleared at issue keeps it pending
        write_en(4'b0001);
        pulse_src(4'b0001);
        tick();
        bus.irq_src = 4'b0001;
        tick();
        bus.irq_src = 4'b0000;
        check("sc_int", 16'(bus.interrupt), 16'd1);
        check("sc_pend", 16'(bus.irq_pending), 16'b0001);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
